// File: rtl/modacc_pkg.sv
// modacc_pkg: default widths, derived-width helper and beat struct for the modular accumulator stage.
package modacc_pkg;
  localparam int DEF_IN_W = 20;
  localparam int DEF_ACC_W = 21;
  localparam int DEF_FOLD_W = 18;
  localparam int DEF_CH = 4;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int DEF_TA_W = DEF_ACC_W - DEF_FOLD_W;
  localparam int DEF_CH_W = ch_w(DEF_CH);
  typedef struct packed {
    logic [DEF_CH_W-1:0] ch;
    logic [DEF_IN_W-1:0] a;
    logic first;
    logic last;
    logic trunc;
  } beat_t;
endpackage

// File: rtl/modaccum_bank.sv
// modaccum_bank: per-channel {ovf, acc} register array with one read and one write port on the same channel.
module modaccum_bank
  import modacc_pkg::*;
#(
  parameter int W = DEF_ACC_W + 1,
  parameter int CH = DEF_CH,
  localparam int CH_W = ch_w(CH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [CH_W-1:0] ch,
  input  logic            we,
  input  logic [W-1:0]    wdata,
  output logic [W-1:0]    rdata
);
  logic [W-1:0] mem_q [CH];
  logic [W-1:0] mem_d [CH];
  assign rdata = mem_q[ch];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[ch] = wdata;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  end
endmodule

// File: rtl/modaccum_stage_mc.sv
// modaccum_stage_mc: multi-channel modular accumulator with framing, fold-to-LUT-address and sticky overflow.
module modaccum_stage_mc
  import modacc_pkg::*;
#(
  parameter int IN_W = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int FOLD_W = DEF_FOLD_W,
  parameter int CH = DEF_CH,
  localparam int TA_W = ACC_W - FOLD_W,
  localparam int CH_W = ch_w(CH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [IN_W-1:0]  in_a,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_trunc,
  output logic             trunc_valid,
  output logic [CH_W-1:0]  trunc_ch,
  output logic [TA_W-1:0]  trunc_adr,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [ACC_W-1:0] out_result,
  output logic             out_ovf,
  output logic             bad_ch
);
  logic ch_ok, ok, ovf_new;
  logic [ACC_W:0] rd, wd, sum;
  logic [ACC_W-1:0] acc, fb;
  logic trunc_valid_d, trunc_valid_q, out_valid_d, out_valid_q, out_ovf_d, out_ovf_q, bad_ch_d, bad_ch_q;
  logic [CH_W-1:0] trunc_ch_d, trunc_ch_q, out_ch_d, out_ch_q;
  logic [TA_W-1:0] trunc_adr_d, trunc_adr_q;
  logic [ACC_W-1:0] out_result_d, out_result_q;
  // a power-of-two channel count leaves no unreachable channel numbers to reject
  if (CH == 2 ** CH_W) begin : g_full
    assign ch_ok = 1'b1;
  end else begin : g_part
    assign ch_ok = in_ch < CH_W'(CH);
  end
  modaccum_bank #(.W(ACC_W + 1), .CH(CH)) u_bank (
    .clk(clk), .reset_n(reset_n), .ch(in_ch), .we(ok), .wdata(wd), .rdata(rd)
  );
  always_comb begin
    ok = in_valid & ch_ok;
    acc = rd[ACC_W-1:0];
    fb = in_first ? '0 : in_trunc ? {{TA_W{1'b0}}, acc[FOLD_W-1:0]} : acc;
    sum = {1'b0, fb} + (ACC_W + 1)'(in_a);
    ovf_new = (~in_first & rd[ACC_W]) | sum[ACC_W];
    wd = {ovf_new, sum[ACC_W-1:0]};
    trunc_valid_d = ok & in_trunc & ~in_first;
    trunc_ch_d = trunc_valid_d ? in_ch : trunc_ch_q;
    trunc_adr_d = trunc_valid_d ? acc[ACC_W-1:FOLD_W] : '0;
    out_valid_d = ok & in_last;
    out_ch_d = out_valid_d ? in_ch : out_ch_q;
    out_result_d = out_valid_d ? sum[ACC_W-1:0] : out_result_q;
    out_ovf_d = out_valid_d ? ovf_new : out_ovf_q;
    bad_ch_d = in_valid & ~ch_ok;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      trunc_valid_q <= 1'b0;
      trunc_ch_q <= '0;
      trunc_adr_q <= '0;
      out_valid_q <= 1'b0;
      out_ch_q <= '0;
      out_result_q <= '0;
      out_ovf_q <= 1'b0;
      bad_ch_q <= 1'b0;
    end else begin
      trunc_valid_q <= trunc_valid_d;
      trunc_ch_q <= trunc_ch_d;
      trunc_adr_q <= trunc_adr_d;
      out_valid_q <= out_valid_d;
      out_ch_q <= out_ch_d;
      out_result_q <= out_result_d;
      out_ovf_q <= out_ovf_d;
      bad_ch_q <= bad_ch_d;
    end
  end
  assign trunc_valid = trunc_valid_q;
  assign trunc_ch = trunc_ch_q;
  assign trunc_adr = trunc_adr_q;
  assign out_valid = out_valid_q;
  assign out_ch = out_ch_q;
  assign out_result = out_result_q;
  assign out_ovf = out_ovf_q;
  assign bad_ch = bad_ch_q;
endmodule

// File: tb/tb_modaccum_stage_mc.sv
// tb_modaccum_stage_mc: scoreboard bench; CH=5 so that channel numbers 5..7 are representable and rejected.
module tb_modaccum_stage_mc;
  localparam int CH = 5;
  logic clk = 1'b0, reset_n = 1'b0;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, in_trunc = 1'b0;
  logic [2:0] in_ch = '0;
  logic [19:0] in_a = '0;
  logic trunc_valid, out_valid, out_ovf, bad_ch;
  logic [2:0] trunc_ch, out_ch, trunc_adr;
  logic [20:0] out_result;
  typedef struct packed {
    logic tv; logic [2:0] tch; logic [2:0] tadr;
    logic ov; logic [2:0] och; logic [20:0] ores; logic oovf; logic bad;
  } obs_t;
  obs_t exp_q[$];
  obs_t hold = '0;
  logic [20:0] acc_m [CH];
  logic ovf_m [CH];
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  modaccum_stage_mc #(.IN_W(20), .ACC_W(21), .FOLD_W(18), .CH(CH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ch(in_ch), .in_a(in_a),
    .in_first(in_first), .in_last(in_last), .in_trunc(in_trunc),
    .trunc_valid(trunc_valid), .trunc_ch(trunc_ch), .trunc_adr(trunc_adr),
    .out_valid(out_valid), .out_ch(out_ch), .out_result(out_result), .out_ovf(out_ovf), .bad_ch(bad_ch)
  );
  function automatic obs_t sample();
    return '{trunc_valid, trunc_ch, trunc_adr, out_valid, out_ch, out_result, out_ovf, bad_ch};
  endfunction
  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin
      acc_m[i] = '0;
      ovf_m[i] = 1'b0;
    end
    hold = '0;
  endtask
  task automatic drive(input logic v, input logic [2:0] ch, input logic [19:0] a, input logic f, l, t);
    obs_t e;
    logic [21:0] s;
    logic [20:0] cur, fb;
    logic nov;
    in_valid = v; in_ch = ch; in_a = a; in_first = f; in_last = l; in_trunc = t;
    e = '0;
    e.tch = hold.tch; e.och = hold.och; e.ores = hold.ores; e.oovf = hold.oovf;
    if (v && ch < CH) begin
      cur = acc_m[ch];
      fb = f ? 21'd0 : t ? (cur & 21'h3FFFF) : cur;
      s = {1'b0, fb} + {2'b00, a};
      nov = (!f && ovf_m[ch]) || s[21];
      if (t && !f) begin e.tv = 1'b1; e.tch = ch; e.tadr = cur[20:18]; end
      if (l) begin e.ov = 1'b1; e.och = ch; e.ores = s[20:0]; e.oovf = nov; end
      acc_m[ch] = s[20:0];
      ovf_m[ch] = nov;
    end else if (v) e.bad = 1'b1;
    hold = e;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic test_reset();
    obs_t got, e;
    drive(1, 0, 20'd50, 1, 0, 0);
    got = sample(); e = exp_q.pop_front(); vec++;
    if (got !== e) begin errs++; $display("FAIL reset_pre: got %h expected %h", got, e); end
    reset_n = 1'b0;
    in_valid = 1'b1; in_ch = 3'd0; in_a = 20'd9; in_last = 1'b1; in_trunc = 1'b1; in_first = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = sample(); vec++;
      if (got !== obs_t'(0)) begin errs++; $display("FAIL reset_hold[%0d]: got %h expected 0", i, got); end
    end
    reset_n = 1'b1; in_valid = 1'b0;
    model_clear();
    drive(1, 0, 20'd7, 0, 1, 0);
    got = sample(); e = exp_q.pop_front(); vec++;
    if (got !== e || got.ores !== 21'd7) begin errs++; $display("FAIL reset_post: got %h expected %h", got, e); end
  endtask
  task automatic test_accum();
    obs_t got, e;
    logic [19:0] as [3] = '{20'd100, 20'd200, 20'd300};
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, as[i], i == 0, i == 2, 0);
      got = sample(); e = exp_q.pop_front(); vec++;
      if (got !== e) begin errs++; $display("FAIL accum[%0d]: got %h expected %h", i, got, e); end
    end
    vec++;
    if (!(got.ov === 1'b1 && got.och === 3'd0 && got.ores === 21'd600 && got.oovf === 1'b0)) begin
      errs++; $display("FAIL accum_600: got result %0d ovf %b expected 600 ovf 0", got.ores, got.oovf);
    end
  endtask
  task automatic test_fold();
    obs_t got, e;
    logic [19:0] as [7] = '{20'h3FFFF, 20'h5, 20'h1, 20'h0, 20'h3, 20'h7FFFF, 20'h2};
    logic fs [7] = '{1, 0, 0, 0, 1, 1, 0};
    logic ls [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic ts [7] = '{0, 0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, as[i], fs[i], ls[i], ts[i]);
      got = sample(); e = exp_q.pop_front(); vec++;
      if (got !== e) begin errs++; $display("FAIL fold[%0d]: got %h expected %h", i, got, e); end
      vec++;
      if (i == 2 && !(got.tv === 1'b1 && got.tch === 3'd1 && got.tadr === 3'd1)) begin
        errs++; $display("FAIL fold_adr: got tv %b ch %0d adr %0d expected 1 1 1", got.tv, got.tch, got.tadr);
      end else if (i == 3 && !(got.ores === 21'd5 && got.tadr === 3'd0 && got.tv === 1'b0)) begin
        errs++; $display("FAIL fold_result: got %h adr %0d expected 5 adr 0", got.ores, got.tadr);
      end else if (i == 4 && got.tv !== 1'b0) begin
        errs++; $display("FAIL fold_first: got tv %b expected 0", got.tv);
      end else if (i == 6 && !(got.tv === 1'b1 && got.tadr === 3'd1 && got.ov === 1'b1 && got.ores === 21'h40001)) begin
        errs++; $display("FAIL fold_last: got tv %b adr %0d result %h expected 1 1 40001", got.tv, got.tadr, got.ores);
      end
    end
  endtask
  task automatic test_overflow();
    obs_t got, e;
    logic [19:0] as [5] = '{20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'h0, 20'h1};
    logic fs [5] = '{1, 0, 0, 0, 1};
    logic ls [5] = '{0, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      drive(1, 2, as[i], fs[i], ls[i], 0);
      got = sample(); e = exp_q.pop_front(); vec++;
      if (got !== e) begin errs++; $display("FAIL ovf[%0d]: got %h expected %h", i, got, e); end
      vec++;
      if (i == 3 && !(got.oovf === 1'b1 && got.ores === 21'h0FFFFD)) begin
        errs++; $display("FAIL ovf_set: got ovf %b result %h expected 1 0ffffd", got.oovf, got.ores);
      end else if (i == 4 && !(got.oovf === 1'b0 && got.ores === 21'd1)) begin
        errs++; $display("FAIL ovf_clear: got ovf %b result %h expected 0 1", got.oovf, got.ores);
      end
    end
  endtask
  task automatic test_back_to_back();
    obs_t got, e;
    logic [2:0] ch;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 2; j++) begin
        ch = j == 0 ? 3'd0 : 3'd3;
        drive(1, ch, 20'(ch * 10 + k), k == 0, k == 7, 0);
        got = sample(); e = exp_q.pop_front(); vec++;
        if (got !== e) begin errs++; $display("FAIL interleave[%0d,%0d]: got %h expected %h", ch, k, got, e); end
        if (k == 7) begin
          vec++;
          if (got.ores !== (ch == 0 ? 21'd28 : 21'd268) || got.och !== ch) begin
            errs++; $display("FAIL interleave_sum ch%0d: got %0d on ch %0d", ch, got.ores, got.och);
          end
        end
      end
    end
    drive(1, 3, 20'd42, 1, 1, 0);
    got = sample(); e = exp_q.pop_front(); vec++;
    if (got !== e || got.ores !== 21'd42 || got.oovf !== 1'b0) begin
      errs++; $display("FAIL first_last: got %h expected %h", got, e);
    end
  endtask
  task automatic test_bad_ch();
    obs_t got, e;
    logic [2:0] chs [8] = '{3'd5, 3'd7, 3'd0, 3'd6, 3'd1, 3'd4, 3'd0, 3'd3};
    logic vs [8] = '{1, 1, 0, 1, 0, 0, 1, 1};
    for (int i = 0; i < 8; i++) begin
      drive(vs[i], chs[i], vs[i] && i < 6 ? 20'd999 : (vs[i] ? 20'd0 : 20'($urandom)), vs[i] ? 1'b0 : 1'($urandom),
            i >= 6 || !vs[i], vs[i] ? 1'b0 : 1'($urandom));
      got = sample(); e = exp_q.pop_front(); vec++;
      if (got !== e) begin errs++; $display("FAIL bad_ch[%0d]: got %h expected %h", i, got, e); end
      vec++;
      if (vs[i] && chs[i] >= CH && !(got.bad === 1'b1 && got.ov === 1'b0 && got.tv === 1'b0)) begin
        errs++; $display("FAIL bad_strobe[%0d]: got bad %b ov %b tv %b expected 1 0 0", i, got.bad, got.ov, got.tv);
      end else if (i == 6 && got.ores !== 21'd28) begin
        errs++; $display("FAIL bad_hold ch0: got %0d expected 28", got.ores);
      end else if (i == 7 && got.ores !== 21'd42) begin
        errs++; $display("FAIL bad_hold ch3: got %0d expected 42", got.ores);
      end
    end
  endtask
  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_accum();
    test_fold();
    test_overflow();
    test_back_to_back();
    test_bad_ch();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
